pp_wr_arbiter: RTL and testbench

Round-robin write-port arbiter and tile sequencer for the ping-pong activation buffer. Shares the buffer's single 32-bit write handshake among NREQ upstream producers (DMA, im2col unit, host loader). Locks a granted producer for a whole tile, so tiles from different sources never interleave inside one buffer half. Reports which source filled each tile and counts completed tiles.

---
 rtl/pp_wr_if.sv | 31 +++
 rtl/pp_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_pp_wr_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_wr_if.sv
// Write handshake bundle between the upstream producers, the arbiter and the
// ping-pong buffer write port.
//   req_valid   NREQ          per-producer beat valid
//   req_data    NREQ*DATA_W   per-producer beat data, producer i at [i*DATA_W +: DATA_W]
//   req_ready   NREQ          per-producer beat accept
//   buf_wr_acq  1             write request towards the buffer
//   buf_wr_rdy  1             buffer write half available
//   buf_wr_data DATA_W        write data towards the buffer
// slave  : arbiter side.
// master : environment side (producers plus buffer).
interface pp_wr_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   buf_wr_acq;
  logic                   buf_wr_rdy;
  logic [DATA_W-1:0]      buf_wr_data;

  modport slave (
    input  req_valid, req_data, buf_wr_rdy,
    output req_ready, buf_wr_acq, buf_wr_data
  );

  modport master (
    output req_valid, req_data, buf_wr_rdy,
    input  req_ready, buf_wr_acq, buf_wr_data
  );
endinterface

// File: rtl/pp_wr_arbiter.sv
// Round-robin write-port arbiter and tile sequencer for the ping-pong
// activation buffer. One producer owns the buffer write port for a whole
// tile of BEATS beats so tiles never interleave inside one buffer half.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   bus           handshake bundle (pp_wr_if.slave)
//   grant_o       one-hot owner of the current tile, 0 when idle
//   busy_o        tile burst in progress
//   tile_done_o   one-cycle pulse after the last beat of a tile
//   tile_src_o    index of the producer that completed the last tile
//   tile_count_o  completed tiles since reset, wrapping
//
// state | meaning
// IDLE  | no owner; round-robin pick among valid producers
// BURST | owner locked until BEATS beats have been accepted
module pp_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pp_wr_if.slave                   bus,
  output logic [NREQ-1:0]          grant_o,
  output logic                     busy_o,
  output logic                     tile_done_o,
  output logic [$clog2(NREQ)-1:0]  tile_src_o,
  output logic [CNT_W-1:0]         tile_count_o
);
  localparam int SRC_W = $clog2(NREQ);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [SRC_W-1:0]   owner_q, owner_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]   tile_src_q, tile_src_d;
  logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
  logic               tile_done_q, tile_done_d;
  logic [CNT_W-1:0]   tile_count_q, tile_count_d;

  logic               found;
  logic [SRC_W-1:0]   win, cand;
  logic               owner_valid;
  logic [DATA_W-1:0]  owner_data;
  logic               busy, beat_acc, last_beat;

  // First valid producer at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = SRC_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == SRC_W'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign busy      = (state_q == BURST);
  assign beat_acc  = busy & owner_valid & bus.buf_wr_rdy;
  assign last_beat = (beat_cnt_q == BCW'(BEATS - 1));

  // Combinational pass-through from the owner to the buffer port.
  assign bus.buf_wr_acq  = busy & owner_valid;
  assign bus.buf_wr_data = busy ? owner_data : '0;
  assign bus.req_ready   = (busy & bus.buf_wr_rdy) ? grant_q : '0;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    beat_cnt_d   = beat_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    tile_done_d  = 1'b0;
    tile_src_d   = tile_src_q;
    tile_count_d = tile_count_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = BURST;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          beat_cnt_d   = '0;
        end
      end
      BURST: begin
        if (beat_acc) begin
          if (last_beat) begin
            state_d      = IDLE;
            grant_d      = '0;
            beat_cnt_d   = '0;
            rr_ptr_d     = (owner_q == SRC_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            tile_done_d  = 1'b1;
            tile_src_d   = owner_q;
            tile_count_d = tile_count_q + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      beat_cnt_q   <= '0;
      rr_ptr_q     <= '0;
      tile_done_q  <= 1'b0;
      tile_src_q   <= '0;
      tile_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      tile_done_q  <= tile_done_d;
      tile_src_q   <= tile_src_d;
      tile_count_q <= tile_count_d;
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = busy;
  assign tile_done_o  = tile_done_q;
  assign tile_src_o   = tile_src_q;
  assign tile_count_o = tile_count_q;
endmodule

// File: tb/tb_pp_wr_arbiter.sv
// Testbench for pp_wr_arbiter: directed scenarios plus a randomized run
// against an integer-level round-robin tile model.
module tb_pp_wr_arbiter;
  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pp_wr_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus  ();
  pp_wr_if #(.NREQ(2),    .DATA_W(DATA_W)) bus2 ();

  logic [3:0]  grant;
  logic        busy, tile_done;
  logic [1:0]  tile_src;
  logic [15:0] tile_count;

  logic [1:0]  grant2;
  logic        busy2, tile_done2;
  logic [0:0]  tile_src2;
  logic [1:0]  tile_count2;

  pp_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .BEATS(BEATS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant_o(grant), .busy_o(busy), .tile_done_o(tile_done),
    .tile_src_o(tile_src), .tile_count_o(tile_count)
  );

  pp_wr_arbiter #(.NREQ(2), .DATA_W(DATA_W), .BEATS(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .grant_o(grant2), .busy_o(busy2), .tile_done_o(tile_done2),
    .tile_src_o(tile_src2), .tile_count_o(tile_count2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.buf_wr_rdy  = 1'b1;
    bus2.req_valid  = '0;
    bus2.req_data   = '0;
    bus2.buf_wr_rdy = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid   = 4'b1111;
    bus.req_data    = {$urandom, $urandom, $urandom, $urandom};
    bus.buf_wr_rdy  = 1'b1;
    bus2.req_valid  = '0;
    bus2.req_data   = '0;
    bus2.buf_wr_rdy = 1'b1;
    tick();
    tick();
    settle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (tile_done !== 1'b0) $display("FAIL reset_tile_done got=%b exp=0", tile_done); else n_pass++;
    n_checks++; if (tile_src !== 2'd0) $display("FAIL reset_tile_src got=%0d exp=0", tile_src); else n_pass++;
    n_checks++; if (tile_count !== 16'd0) $display("FAIL reset_tile_count got=%0d exp=0", tile_count); else n_pass++;
    n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); else n_pass++;
    n_checks++; if (bus.buf_wr_acq !== 1'b0) $display("FAIL reset_acq got=%b exp=0", bus.buf_wr_acq); else n_pass++;
    n_checks++; if (bus.buf_wr_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", bus.buf_wr_data); else n_pass++;
    bus.req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_data  = '0;
    bus.req_data[31:0] = 32'h11;
    settle();
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy got=%b exp=0", busy); else n_pass++;
    tick();
    for (int b = 0; b < BEATS; b++) begin
      bus.req_data[31:0] = 32'h11 + b;
      settle();
      n_checks++; if (grant !== 4'b0001) $display("FAIL single_grant beat%0d got=%b exp=0001", b, grant); else n_pass++;
      n_checks++; if (bus.buf_wr_data !== 32'h11 + b) $display("FAIL single_data beat%0d got=%h exp=%h", b, bus.buf_wr_data, 32'h11 + b); else n_pass++;
      n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL single_ready beat%0d got=%b exp=0001", b, bus.req_ready); else n_pass++;
      n_checks++; if (tile_done !== 1'b0) $display("FAIL single_early_done beat%0d got=%b exp=0", b, tile_done); else n_pass++;
      tick();
    end
    settle();
    n_checks++; if (tile_done !== 1'b1) $display("FAIL single_done got=%b exp=1", tile_done); else n_pass++;
    n_checks++; if (tile_src !== 2'd0) $display("FAIL single_src got=%0d exp=0", tile_src); else n_pass++;
    n_checks++; if (tile_count !== 16'd1) $display("FAIL single_count got=%0d exp=1", tile_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_gap_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (bus.buf_wr_acq !== 1'b0) $display("FAIL single_gap_acq got=%b exp=0", bus.buf_wr_acq); else n_pass++;
    tick();
    settle();
    n_checks++; if (busy !== 1'b1) $display("FAIL single_regrant_busy got=%b exp=1", busy); else n_pass++;
    n_checks++; if (grant !== 4'b0001) $display("FAIL single_regrant got=%b exp=0001", grant); else n_pass++;
    n_checks++; if (tile_done !== 1'b0) $display("FAIL single_done_pulse got=%b exp=0", tile_done); else n_pass++;
  endtask

  task automatic collect_order(input logic [3:0] valid, input int ntiles, output int order[$]);
    order = {};
    bus.req_valid  = valid;
    bus.buf_wr_rdy = 1'b1;
    for (int cyc = 0; cyc < 20 * ntiles && order.size() < ntiles; cyc++) begin
      bus.req_data = {$urandom, $urandom, $urandom, $urandom};
      settle();
      if (tile_done) order.push_back(int'(tile_src));
      tick();
    end
  endtask

  task automatic test_alternate();
    int order[$];
    do_reset();
    bus.req_valid = 4'b0101;
    for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
      bus.req_data = {$urandom, $urandom, $urandom, $urandom};
      settle();
      if (grant === 4'b0001) begin
        n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL alt_ready_owner0 got=%b exp=0001", bus.req_ready); else n_pass++;
      end
      if (tile_done) order.push_back(int'(tile_src));
      tick();
    end
    n_checks++; if (order.size() != 4) $display("FAIL alt_tiles got=%0d exp=4", order.size()); else n_pass++;
    for (int i = 0; i < order.size(); i++) begin
      n_checks++; if (order[i] != ((i % 2) * 2)) $display("FAIL alt_order tile%0d got=%0d exp=%0d", i, order[i], (i % 2) * 2); else n_pass++;
    end
    settle();
    n_checks++; if (tile_count !== 16'd4) $display("FAIL alt_count got=%0d exp=4", tile_count); else n_pass++;
  endtask

  task automatic test_owner_drop();
    do_reset();
    bus.req_valid = 4'b1010;
    bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    for (int b = 0; b < 2; b++) begin
      settle();
      n_checks++; if (grant !== 4'b0010) $display("FAIL drop_grant beat%0d got=%b exp=0010", b, grant); else n_pass++;
      tick();
    end
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_checks++; if (grant !== 4'b0010) $display("FAIL drop_hold_grant c%0d got=%b exp=0010", c, grant); else n_pass++;
      n_checks++; if (bus.buf_wr_acq !== 1'b0) $display("FAIL drop_acq c%0d got=%b exp=0", c, bus.buf_wr_acq); else n_pass++;
      n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL drop_ready c%0d got=%b exp=0010", c, bus.req_ready); else n_pass++;
      tick();
    end
    bus.req_valid = 4'b1010;
    for (int b = 2; b < 4; b++) begin
      settle();
      n_checks++; if (tile_done !== 1'b0) $display("FAIL drop_early_done beat%0d got=%b exp=0", b, tile_done); else n_pass++;
      n_checks++; if (bus.buf_wr_acq !== 1'b1) $display("FAIL drop_resume_acq beat%0d got=%b exp=1", b, bus.buf_wr_acq); else n_pass++;
      tick();
    end
    settle();
    n_checks++; if (tile_done !== 1'b1) $display("FAIL drop_done got=%b exp=1", tile_done); else n_pass++;
    n_checks++; if (tile_src !== 2'd1) $display("FAIL drop_src got=%0d exp=1", tile_src); else n_pass++;
    tick();
    settle();
    n_checks++; if (grant !== 4'b1000) $display("FAIL drop_next_grant got=%b exp=1000", grant); else n_pass++;
  endtask

  task automatic test_rdy_stall();
    int pat[7] = '{1, 1, 0, 0, 0, 1, 1};
    do_reset();
    bus.req_valid  = 4'b0001;
    bus.buf_wr_rdy = 1'b0;
    settle();
    n_checks++; if (busy !== 1'b0) $display("FAIL stall_idle_busy got=%b exp=0", busy); else n_pass++;
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.buf_wr_rdy = (pat[i] != 0);
      bus.req_data   = {$urandom, $urandom, $urandom, $urandom};
      settle();
      n_checks++; if (bus.buf_wr_acq !== 1'b1) $display("FAIL stall_acq c%0d got=%b exp=1", i, bus.buf_wr_acq); else n_pass++;
      n_checks++; if (bus.req_ready !== ((pat[i] != 0) ? 4'b0001 : 4'b0000)) $display("FAIL stall_ready c%0d got=%b rdy=%0d", i, bus.req_ready, pat[i]); else n_pass++;
      n_checks++; if (tile_done !== 1'b0) $display("FAIL stall_early_done c%0d got=%b exp=0", i, tile_done); else n_pass++;
      tick();
    end
    bus.req_valid = 4'b0000;
    settle();
    n_checks++; if (tile_done !== 1'b1) $display("FAIL stall_done got=%b exp=1", tile_done); else n_pass++;
    n_checks++; if (tile_count !== 16'd1) $display("FAIL stall_count got=%0d exp=1", tile_count); else n_pass++;
    tick();
    settle();
    n_checks++; if (tile_done !== 1'b0) $display("FAIL stall_done_once got=%b exp=0", tile_done); else n_pass++;
    n_checks++; if (tile_count !== 16'd1) $display("FAIL stall_count_hold got=%0d exp=1", tile_count); else n_pass++;
  endtask

  task automatic test_rr_wrap();
    int order[$];
    do_reset();
    collect_order(4'b1111, 5, order);
    n_checks++; if (order.size() != 5) $display("FAIL wrap_tiles got=%0d exp=5", order.size()); else n_pass++;
    for (int i = 0; i < order.size(); i++) begin
      n_checks++; if (order[i] != (i % NREQ)) $display("FAIL wrap_order tile%0d got=%0d exp=%0d", i, order[i], i % NREQ); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 5; c++) tick();
    settle();
    n_checks++; if (tile_count !== 16'd1) $display("FAIL rmid_first_count got=%0d exp=1", tile_count); else n_pass++;
    tick();
    tick();
    tick();
    settle();
    n_checks++; if (busy !== 1'b1) $display("FAIL rmid_busy got=%b exp=1", busy); else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (grant !== 4'b0000) $display("FAIL rmid_grant got=%b exp=0000", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy_clr got=%b exp=0", busy); else n_pass++;
    n_checks++; if (tile_count !== 16'd0) $display("FAIL rmid_count got=%0d exp=0", tile_count); else n_pass++;
    n_checks++; if (bus.buf_wr_acq !== 1'b0) $display("FAIL rmid_acq got=%b exp=0", bus.buf_wr_acq); else n_pass++;
    n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL rmid_ready got=%b exp=0000", bus.req_ready); else n_pass++;
    n_checks++; if (bus.buf_wr_data !== 32'h0) $display("FAIL rmid_data got=%h exp=0", bus.buf_wr_data); else n_pass++;
    bus.req_valid = 4'b1000;
    tick();
    rst = 1'b0;
    settle();
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_release_busy got=%b exp=0", busy); else n_pass++;
    tick();
    settle();
    n_checks++; if (grant !== 4'b1000) $display("FAIL rmid_regrant got=%b exp=1000", grant); else n_pass++;
    for (int c = 0; c < 4; c++) tick();
    settle();
    n_checks++; if (tile_done !== 1'b1) $display("FAIL rmid_done got=%b exp=1", tile_done); else n_pass++;
    n_checks++; if (tile_src !== 2'd3) $display("FAIL rmid_src got=%0d exp=3", tile_src); else n_pass++;
    n_checks++; if (tile_count !== 16'd1) $display("FAIL rmid_count_after got=%0d exp=1", tile_count); else n_pass++;
  endtask

  task automatic test_cnt_wrap();
    int cnts[$];
    int srcs[$];
    do_reset();
    bus2.req_valid  = 2'b11;
    bus2.buf_wr_rdy = 1'b1;
    for (int cyc = 0; cyc < 100 && cnts.size() < 5; cyc++) begin
      bus2.req_data = {$urandom, $urandom};
      settle();
      if (tile_done2) begin
        cnts.push_back(int'(tile_count2));
        srcs.push_back(int'(tile_src2));
      end
      tick();
    end
    bus2.req_valid = '0;
    n_checks++; if (cnts.size() != 5) $display("FAIL wrap2_tiles got=%0d exp=5", cnts.size()); else n_pass++;
    for (int i = 0; i < cnts.size(); i++) begin
      n_checks++; if (cnts[i] != ((i + 1) % 4)) $display("FAIL wrap2_count tile%0d got=%0d exp=%0d", i, cnts[i], (i + 1) % 4); else n_pass++;
      n_checks++; if (srcs[i] != (i % 2)) $display("FAIL wrap2_src tile%0d got=%0d exp=%0d", i, srcs[i], i % 2); else n_pass++;
    end
  endtask

  // Reference: owner index (-1 when idle), beats taken, next search start,
  // last completed source and modular tile count, all as plain integers.
  task automatic test_random();
    int m_owner, m_beats, m_ptr, m_src, m_count, m_tiles;
    bit m_done;
    logic [3:0]  exp_grant, exp_ready;
    logic [31:0] exp_data;
    logic        exp_acq;
    do_reset();
    m_owner = -1; m_beats = 0; m_ptr = 0; m_src = 0; m_count = 0; m_done = 0; m_tiles = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc == 400) begin
        do_reset();
        m_owner = -1; m_beats = 0; m_ptr = 0; m_src = 0; m_count = 0; m_done = 0;
      end
      bus.req_valid  = 4'($urandom_range(0, 15));
      bus.buf_wr_rdy = ($urandom_range(0, 3) != 0);
      bus.req_data   = {$urandom, $urandom, $urandom, $urandom};
      settle();
      exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      exp_acq   = (m_owner >= 0) && (((bus.req_valid >> m_owner) & 4'd1) != 0);
      exp_data  = (m_owner < 0) ? 32'h0 : 32'(bus.req_data >> (m_owner * DATA_W));
      exp_ready = (m_owner >= 0 && bus.buf_wr_rdy) ? exp_grant : 4'b0000;
      n_checks++; if (grant !== exp_grant) $display("FAIL rnd_grant cyc%0d got=%b exp=%b", cyc, grant, exp_grant); else n_pass++;
      n_checks++; if (busy !== (m_owner >= 0)) $display("FAIL rnd_busy cyc%0d got=%b exp=%b", cyc, busy, m_owner >= 0); else n_pass++;
      n_checks++; if (bus.buf_wr_acq !== exp_acq) $display("FAIL rnd_acq cyc%0d got=%b exp=%b", cyc, bus.buf_wr_acq, exp_acq); else n_pass++;
      n_checks++; if (bus.buf_wr_data !== exp_data) $display("FAIL rnd_data cyc%0d got=%h exp=%h", cyc, bus.buf_wr_data, exp_data); else n_pass++;
      n_checks++; if (bus.req_ready !== exp_ready) $display("FAIL rnd_ready cyc%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready); else n_pass++;
      n_checks++; if (tile_done !== m_done) $display("FAIL rnd_done cyc%0d got=%b exp=%b", cyc, tile_done, m_done); else n_pass++;
      n_checks++; if (int'(tile_src) != m_src) $display("FAIL rnd_src cyc%0d got=%0d exp=%0d", cyc, tile_src, m_src); else n_pass++;
      n_checks++; if (int'(tile_count) != m_count) $display("FAIL rnd_count cyc%0d got=%0d exp=%0d", cyc, tile_count, m_count); else n_pass++;
      m_done = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (m_owner < 0 && (((bus.req_valid >> ((m_ptr + k) % NREQ)) & 4'd1) != 0)) begin
            m_owner = (m_ptr + k) % NREQ;
            m_beats = 0;
          end
        end
      end else if (exp_acq && bus.buf_wr_rdy) begin
        m_beats++;
        if (m_beats == BEATS) begin
          m_done  = 1;
          m_src   = m_owner;
          m_count = (m_count + 1) % (1 << CNT_W);
          m_ptr   = (m_owner + 1) % NREQ;
          m_owner = -1;
          m_tiles++;
        end
      end
      tick();
    end
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_owner_drop();
    test_rdy_stall();
    test_rr_wrap();
    test_reset_mid();
    test_cnt_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
